// File: rtl/adc_to_float.sv
// adc_to_float: signed ADC sample -> exact IEEE-754 float32, scaled by 2^-EXP_SHIFT via the exponent.
// Define ADC_TO_FLOAT_FAST_NORM_EN for single-cycle normalization (priority encoder + barrel shift).
module adc_to_float #(
    parameter int IN_WIDTH  = 24,
    parameter int EXP_SHIFT = 0
) (
    input  logic                       i_CLK,
    input  logic                       i_RSTN,
    input  logic signed [IN_WIDTH-1:0] i_ADC_DATA,
    input  logic                       i_ADC_DATA_VALID,
    output logic                       o_ADC_DATA_READY,
    output logic [31:0]                o_Z_DATA,
    output logic                       o_Z_DATA_VALID,
    input  logic                       i_Z_DATA_READY
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } state_t;

    // 150 = bias 127 + 23: a value whose leading one sits at mag[23] needs no shift.
    localparam logic [7:0] EXP_INIT = 8'(150 - EXP_SHIFT);

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [23:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] z_data_q, z_data_d;
    logic        z_valid_q, z_valid_d;
    logic        adc_ready_q, adc_ready_d;

    logic        accept;
    logic        xfer;
    logic [23:0] sample_ext;
    logic [23:0] sample_mag;

    logic        norm_done;
    logic [7:0]  res_exp;
    logic [22:0] res_frac;
    logic [23:0] step_mag;
    logic [7:0]  step_exp;

    assign accept     = i_ADC_DATA_VALID && adc_ready_q;
    assign xfer       = z_valid_q && i_Z_DATA_READY;
    assign sample_ext = 24'(i_ADC_DATA);
    // The most negative sample negates onto itself, which read unsigned is exactly 2^(IN_WIDTH-1).
    assign sample_mag = sample_ext[23] ? (~sample_ext + 24'd1) : sample_ext;

`ifdef ADC_TO_FLOAT_FAST_NORM_EN
    logic [4:0] lead_shift;

    always_comb begin
        lead_shift = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (mag_q[i]) lead_shift = 5'(23 - i);
        end
        norm_done = 1'b1;
        res_exp   = exp_q - {3'b000, lead_shift};
        res_frac  = 23'(mag_q << lead_shift);
        step_mag  = mag_q;
        step_exp  = exp_q;
    end
`else
    always_comb begin
        norm_done = mag_q[23];
        res_exp   = exp_q;
        res_frac  = mag_q[22:0];
        step_mag  = {mag_q[22:0], 1'b0};
        step_exp  = exp_q - 8'd1;
    end
`endif

    // NOTE: flops take only non-blocking assignments so every register samples pre-edge _d values.
    always_ff @(posedge i_CLK) begin
        if (!i_RSTN) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 24'd0;
            exp_q       <= 8'd0;
            z_data_q    <= 32'h0;
            z_valid_q   <= 1'b0;
            adc_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            z_data_q    <= z_data_d;
            z_valid_q   <= z_valid_d;
            adc_ready_q <= adc_ready_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = NORM;
            NORM:    if (mag_q == 24'd0 || norm_done) state_d = OUT;
            OUT:     if (xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every _d gets its hold/default value before the case, so no path can infer a latch.
    always_comb begin : outputs_next
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        z_data_d    = z_data_q;
        z_valid_d   = 1'b0;
        adc_ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                adc_ready_d = !accept;
                if (accept) begin
                    sign_d = sample_ext[23];
                    mag_d  = sample_mag;
                    exp_d  = EXP_INIT;
                end
            end
            NORM: begin
                if (mag_q == 24'd0) begin
                    z_data_d = 32'h0;
                end else if (norm_done) begin
                    z_data_d = {sign_q, res_exp, res_frac};
                end else begin
                    mag_d = step_mag;
                    exp_d = step_exp;
                end
            end
            OUT: begin
                z_valid_d   = !xfer;
                adc_ready_d = xfer;
            end
            default: ;
        endcase
    end

    assign o_ADC_DATA_READY = adc_ready_q;
    assign o_Z_DATA         = z_data_q;
    assign o_Z_DATA_VALID   = z_valid_q;

endmodule

// File: tb/tb_adc_to_float.sv
// Scoreboard bench for adc_to_float: a driver pushes model results, a monitor pops on each output.
// Instance 0 uses EXP_SHIFT=0, instance 1 uses EXP_SHIFT=10; only one is exercised at a time.
module tb_adc_to_float;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [23:0] adc_data [2];
    logic [1:0]  adc_valid;
    logic [1:0]  adc_ready;
    logic [31:0] z_data [2];
    logic [1:0]  z_valid;
    logic [1:0]  z_ready;
    logic        hold;

    adc_to_float #(.IN_WIDTH(24), .EXP_SHIFT(0)) dut0 (
        .i_CLK(clk), .i_RSTN(rstn),
        .i_ADC_DATA(adc_data[0]), .i_ADC_DATA_VALID(adc_valid[0]), .o_ADC_DATA_READY(adc_ready[0]),
        .o_Z_DATA(z_data[0]), .o_Z_DATA_VALID(z_valid[0]), .i_Z_DATA_READY(z_ready[0])
    );

    adc_to_float #(.IN_WIDTH(24), .EXP_SHIFT(10)) dut1 (
        .i_CLK(clk), .i_RSTN(rstn),
        .i_ADC_DATA(adc_data[1]), .i_ADC_DATA_VALID(adc_valid[1]), .o_ADC_DATA_READY(adc_ready[1]),
        .o_Z_DATA(z_data[1]), .o_Z_DATA_VALID(z_valid[1]), .i_Z_DATA_READY(z_ready[1])
    );

    typedef struct {
        int          dut;
        logic [31:0] z;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Float from first principles: value = (-1)^s * 2^e * 1.f, with e = floor(log2|x|).
    function automatic logic [31:0] ref_float(input int x, input int shift, output int s);
        int  m;
        int  e;
        logic sgn;
        if (x == 0) begin
            s = 0;
            return 32'h0;
        end
        sgn = (x < 0);
        m   = sgn ? -x : x;
        e   = 0;
        while ((m >> (e + 1)) != 0) e++;
        s = 23 - e;
        return {sgn, 8'(127 + e - shift), 23'((m - (1 << e)) << (23 - e))};
    endfunction

    function automatic int ref_latency(input int s);
`ifdef ADC_TO_FLOAT_FAST_NORM_EN
        return 2 + 0 * s;
`else
        return 2 + s;
`endif
    endfunction

    // Downstream ready changes just after the edge so it is stable when the monitor samples.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) z_ready[g] = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    logic [1:0]  prev_zv = 2'b00;
    logic [1:0]  prev_xfer = 2'b00;
    logic [31:0] prev_z [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (prev_xfer[g]) begin
                check($sformatf("ready_after_xfer%0d", g), 32'(adc_ready[g]), 32'd1);
                check($sformatf("valid_after_xfer%0d", g), 32'(z_valid[g]), 32'd0);
            end
            prev_xfer[g] = 1'b0;
            if (z_valid[g]) begin
                check($sformatf("ready_low_busy%0d", g), 32'(adc_ready[g]), 32'd0);
                if (!prev_zv[g]) begin
                    if (sb.size() == 0 || sb[0].dut != g) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_valid%0d: got %h, expected no output", g, z_data[g]);
                    end else begin
                        check($sformatf("result%0d", g), z_data[g], sb[0].z);
                        check($sformatf("latency%0d", g), 32'(cyc), 32'(sb[0].due));
                    end
                end else begin
                    check($sformatf("hold_stable%0d", g), z_data[g], prev_z[g]);
                end
                if (z_ready[g]) begin
                    prev_xfer[g] = 1'b1;
                    if (sb.size() != 0 && sb[0].dut == g) void'(sb.pop_front());
                end
            end
            prev_zv[g] = z_valid[g];
            prev_z[g]  = z_data[g];
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int g, input logic [23:0] x, input bit expect_it);
        int          k;
        int          s;
        int          xi;
        logic [31:0] z;
        k = 0;
        while (!adc_ready[g] && k < 100) begin
            adc_valid[g] = ($urandom_range(0, 3) == 0);
            adc_data[g]  = 24'($urandom);
            @(negedge clk);
            k++;
        end
        if (!adc_ready[g]) begin
            check("accept_timeout", 32'(adc_ready[g]), 32'd1);
            adc_valid[g] = 1'b0;
            return;
        end
        adc_data[g]  = x;
        adc_valid[g] = 1'b1;
        if (expect_it) begin
            xi = $signed(x);
            z  = ref_float(xi, (g == 1) ? 10 : 0, s);
            sb.push_back('{g, z, cyc + 1 + ref_latency(s)});
        end
        @(negedge clk);
        adc_valid[g] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || z_valid != 2'b00) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    function automatic logic [23:0] rand_sample();
        logic [23:0] r;
        r = 24'($urandom) >> $urandom_range(0, 23);
        if ($urandom_range(0, 1) == 1) r = -r;
        if ($urandom_range(0, 15) == 0) r = 24'h000000;
        if ($urandom_range(0, 15) == 0) r = 24'h800000;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [23:0] directed [5];
        directed = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 24'h000000};
        rstn      = 1'b0;
        hold      = 1'b0;
        adc_valid = 2'b00;
        z_ready   = 2'b00;
        for (int g = 0; g < 2; g++) adc_data[g] = 24'h0;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_ready%0d", g), 32'(adc_ready[g]), 32'd0);
            check($sformatf("rst_valid%0d", g), 32'(z_valid[g]), 32'd0);
            check($sformatf("rst_data%0d", g), z_data[g], 32'h0);
        end
        rstn = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("ready_after_rst%0d", g), 32'(adc_ready[g]), 32'd1);

        foreach (directed[i]) begin
            send(0, directed[i], 1'b1);
            drain();
        end

        // Backpressure: result must hold while downstream stalls; extra samples are ignored.
        hold = 1'b1;
        @(negedge clk);
        send(0, 24'h000003, 1'b1);
        for (int k = 0; k < 40 && !z_valid[0]; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            adc_valid[0] = (k < 3);
            adc_data[0]  = 24'h000005;
            check("bp_valid_held", 32'(z_valid[0]), 32'd1);
            check("bp_data_held", z_data[0], 32'h40400000);
            @(negedge clk);
        end
        adc_valid[0] = 1'b0;
        hold = 1'b0;
        drain();

        // Reset while normalizing discards the sample.
        send(0, 24'h000001, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midrst_ready", 32'(adc_ready[0]), 32'd0);
        check("midrst_valid", 32'(z_valid[0]), 32'd0);
        @(negedge clk);
        check("midrst_ready_back", 32'(adc_ready[0]), 32'd1);
        send(0, 24'h000002, 1'b1);
        drain();

        for (int i = 0; i < 40; i++) begin
            send(0, rand_sample(), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        send(1, 24'd1024, 1'b1);
        drain();
        send(1, -24'd512, 1'b1);
        drain();
        for (int i = 0; i < 12; i++) send(1, rand_sample(), 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
